// File: rtl/alu_32bit.sv
// ---------------------------------------------------------------------------
// alu_32bit
//
// Registered 32-bit integer ALU for the DLX execute stage, with an optional
// IEEE-754 single-precision adder that shares the result register.
// Every output is registered, so results appear one clock after the
// operands. A new operation can be issued every cycle.
//
// Build option:
//   ALU_FPADD_EN  When defined, Op 01111 performs a single-precision float
//                 add. It rounds toward zero and flushes denormals to zero.
//                 When undefined, Op 01111 behaves as an undefined opcode
//                 and no float hardware is built.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst       in   1   synchronous active-high reset
//   A         in   32  operand A
//   B         in   32  operand B (shift amount is B[4:0])
//   Op        in   5   operation select
//   Result    out  32  registered result
//   Carryout  out  1   carry out of bit 31 (add/sub only)
//   Overflow  out  1   signed overflow (add/sub only)
//   Zero      out  1   high when Result is zero
//   Set       out  1   comparison outcome (compare ops only)
// ---------------------------------------------------------------------------
module alu_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  Op,
  output logic [31:0] Result,
  output logic        Carryout,
  output logic        Overflow,
  output logic        Zero,
  output logic        Set
);

  typedef enum logic [4:0] {
    OP_AND  = 5'b00000,
    OP_OR   = 5'b00001,
    OP_ADD  = 5'b00010,
    OP_SUB  = 5'b00011,
    OP_XOR  = 5'b00100,
    OP_SLL  = 5'b00101,
    OP_SRL  = 5'b00110,
    OP_SLTU = 5'b00111,
    OP_SLT  = 5'b01000,
    OP_SGEQ = 5'b01001,
    OP_ADDF = 5'b01111
  } aluOp_e;

  logic [32:0] addSum;
  logic [32:0] subDiff;
  logic        addOverflow;
  logic        subOverflow;
  logic        ltUnsigned;
  logic        ltSigned;

  logic [31:0] result_d, result_q;
  logic        carry_d, carry_q;
  logic        overflow_d, overflow_q;
  logic        zero_d, zero_q;
  logic        set_d, set_q;

  // The subtract uses A + ~B + 1, so bit 32 is the "no borrow" carry.
  assign addSum      = {1'b0, A} + {1'b0, B};
  assign subDiff     = {1'b0, A} + {1'b0, ~B} + 33'd1;
  assign addOverflow = (A[31] == B[31]) && (addSum[31] != A[31]);
  assign subOverflow = (A[31] != B[31]) && (subDiff[31] != A[31]);
  assign ltUnsigned  = A < B;
  assign ltSigned    = $signed(A) < $signed(B);

`ifdef ALU_FPADD_EN
  // -------------------------------------------------------------------------
  // Single-precision adder, fully combinational, round toward zero
  // -------------------------------------------------------------------------
  logic [7:0]         expA, expB;
  logic [22:0]        fracA, fracB;
  logic               nanA, nanB, infA, infB, zeroA, zeroB;
  logic               aBigger;
  logic               bigSign;
  logic [7:0]         bigExp, smallExp, expDiff;
  logic [22:0]        bigFrac, smallFrac;
  logic [26:0]        mantBig, mantSmallRaw, shiftedSmall, mantSmall;
  logic               alignSticky;
  logic               effSub;
  logic [27:0]        mantSum;
  logic [4:0]         leadPos;
  logic [4:0]         lzCount;
  logic [26:0]        normMant;
  logic signed [9:0]  normExp;
  logic [31:0]        fpResult;
  logic               fpUnused;

  // A zero exponent covers both true zeros and denormals.
  // Both are flushed, so both count as zero here.
  assign expA  = A[30:23];
  assign expB  = B[30:23];
  assign fracA = A[22:0];
  assign fracB = B[22:0];
  assign nanA  = (expA == 8'hFF) && (fracA != 23'd0);
  assign nanB  = (expB == 8'hFF) && (fracB != 23'd0);
  assign infA  = (expA == 8'hFF) && (fracA == 23'd0);
  assign infB  = (expB == 8'hFF) && (fracB == 23'd0);
  assign zeroA = (expA == 8'h00);
  assign zeroB = (expB == 8'h00);

  // For normal numbers, the magnitude order matches the raw bit-pattern
  // order. Comparing the raw bits therefore picks the larger operand.
  assign aBigger   = A[30:0] >= B[30:0];
  assign bigSign   = aBigger ? A[31] : B[31];
  assign bigExp    = aBigger ? expA : expB;
  assign smallExp  = aBigger ? expB : expA;
  assign bigFrac   = aBigger ? fracA : fracB;
  assign smallFrac = aBigger ? fracB : fracA;
  assign expDiff   = bigExp - smallExp;

  // Three extra low bits (guard, round, sticky) keep the truncated
  // difference exact enough that round-toward-zero stays correct when
  // the operation is an effective subtraction.
  assign mantBig      = {1'b1, bigFrac, 3'b000};
  assign mantSmallRaw = {1'b1, smallFrac, 3'b000};

  // Align the smaller mantissa. Any bit shifted out is folded into
  // the sticky bit.
  always_comb begin
    shiftedSmall = 27'd0;
    alignSticky  = 1'b0;
    if (expDiff >= 8'd27) begin
      alignSticky = 1'b1;
    end else begin
      shiftedSmall = mantSmallRaw >> expDiff;
      alignSticky  = |(mantSmallRaw & ~(27'h7FFFFFF << expDiff));
    end
  end

  assign mantSmall = {shiftedSmall[26:1], shiftedSmall[0] | alignSticky};
  assign effSub    = A[31] ^ B[31];
  assign mantSum   = effSub ? ({1'b0, mantBig} - {1'b0, mantSmall})
                            : ({1'b0, mantBig} + {1'b0, mantSmall});

  // Normalize so the leading one sits at bit 26.
  // A carry into bit 27 shifts right by one.
  // Cancellation shifts left by the leading-zero count.
  always_comb begin
    leadPos  = 5'd0;
    lzCount  = 5'd0;
    normMant = 27'd0;
    normExp  = 10'sd0;
    for (int i = 0; i < 27; i++) begin
      if (mantSum[i]) leadPos = 5'(i);
    end
    if (mantSum[27]) begin
      normMant = mantSum[27:1];
      normExp  = $signed({2'b00, bigExp}) + 10'sd1;
    end else begin
      lzCount  = 5'd26 - leadPos;
      normMant = mantSum[26:0] << lzCount;
      normExp  = $signed({2'b00, bigExp}) - $signed({5'b00000, lzCount});
    end
  end

  // Special operands take priority over the datapath result.
  // After them come exact cancellation, exponent overflow to infinity,
  // and underflow flushed to zero.
  always_comb begin
    fpResult = 32'd0;
    if (nanA || nanB) begin
      fpResult = 32'h7FC00000;
    end else if (infA && infB && (A[31] != B[31])) begin
      fpResult = 32'h7FC00000;
    end else if (infA) begin
      fpResult = A;
    end else if (infB) begin
      fpResult = B;
    end else if (zeroA && zeroB) begin
      fpResult = {A[31] & B[31], 31'd0};
    end else if (zeroA) begin
      fpResult = B;
    end else if (zeroB) begin
      fpResult = A;
    end else if (mantSum == 28'd0) begin
      fpResult = 32'd0;
    end else if (normExp >= 10'sd255) begin
      fpResult = {bigSign, 8'hFF, 23'd0};
    end else if (normExp <= 10'sd0) begin
      fpResult = {bigSign, 31'd0};
    end else begin
      fpResult = {bigSign, normExp[7:0], normMant[25:3]};
    end
  end

  // These bits are dropped on purpose: the hidden one, the truncated
  // guard bits, and the exponent sign/overflow bits that are already
  // covered by the range checks above.
  assign fpUnused = ^{normMant[26], normMant[2:0], normExp[9:8]};
`endif

  // Select the result and flags for the current opcode.
  // Unknown opcodes fall through to an all-zero result.
  always_comb begin
    result_d   = 32'd0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    set_d      = 1'b0;
    case (aluOp_e'(Op))
      OP_AND: result_d = A & B;
      OP_OR:  result_d = A | B;
      OP_XOR: result_d = A ^ B;
      OP_ADD: begin
        result_d   = addSum[31:0];
        carry_d    = addSum[32];
        overflow_d = addOverflow;
      end
      OP_SUB: begin
        result_d   = subDiff[31:0];
        carry_d    = subDiff[32];
        overflow_d = subOverflow;
      end
      OP_SLL: result_d = A << B[4:0];
      OP_SRL: result_d = A >> B[4:0];
      OP_SLTU: begin
        set_d    = ltUnsigned;
        result_d = {31'd0, ltUnsigned};
      end
      OP_SLT: begin
        set_d    = ltSigned;
        result_d = {31'd0, ltSigned};
      end
      OP_SGEQ: begin
        set_d    = ~ltSigned;
        result_d = {31'd0, ~ltSigned};
      end
`ifdef ALU_FPADD_EN
      OP_ADDF: result_d = fpResult;
`endif
      default: result_d = 32'd0;
    endcase
    zero_d = (result_d == 32'd0);
  end

  // Output register. Reset wins over whatever was computed this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= 32'd0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
      set_q      <= 1'b0;
    end else begin
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      set_q      <= set_d;
    end
  end

  assign Result   = result_q;
  assign Carryout = carry_q;
  assign Overflow = overflow_q;
  assign Zero     = zero_q;
  assign Set      = set_q;

endmodule

// File: tb/tb_alu_32bit.sv
// ---------------------------------------------------------------------------
// tb_alu_32bit
//
// Self-checking bench for alu_32bit.
//
// Inputs are driven on the falling edge of the clock. At the same time the
// expected outputs are pushed onto a scoreboard queue. A monitor pops one
// entry just after each rising edge and compares it with the registered
// outputs.
//
// Integer expectations come from a reference model built on 64-bit
// arithmetic. Float expectations are hand-computed constants. Those
// constants follow ALU_FPADD_EN, so the bench works in either build.
// ---------------------------------------------------------------------------
module tb_alu_32bit;

  typedef struct {
    string       tag;
    logic [31:0] result;
    logic        carry;
    logic        ovf;
    logic        zero;
    logic        set;
  } expect_t;

  logic        clk;
  logic        rst;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [4:0]  opSel;
  logic [31:0] result;
  logic        carryOut;
  logic        overflow;
  logic        zero;
  logic        setFlag;

  expect_t sbQueue[$];
  int      assertCount = 0;
  int      failCount   = 0;

  alu_32bit dut (
    .clk      (clk),
    .rst      (rst),
    .A        (opA),
    .B        (opB),
    .Op       (opSel),
    .Result   (result),
    .Carryout (carryOut),
    .Overflow (overflow),
    .Zero     (zero),
    .Set      (setFlag)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference model using wide signed and unsigned arithmetic
  function automatic expect_t modelAlu(input logic [31:0] a, input logic [31:0] b,
                                       input logic [4:0] op);
    expect_t     m;
    logic [63:0] wide;
    longint      sSum;
    longint      maxS;
    longint      minS;
    maxS     = 64'sd2147483647;
    minS     = -64'sd2147483648;
    m.tag    = "";
    m.result = 32'd0;
    m.carry  = 1'b0;
    m.ovf    = 1'b0;
    m.set    = 1'b0;
    case (op)
      5'd0: m.result = a & b;
      5'd1: m.result = a | b;
      5'd2: begin
        wide     = {32'd0, a} + {32'd0, b};
        m.result = wide[31:0];
        m.carry  = wide[32];
        sSum     = longint'($signed(a)) + longint'($signed(b));
        m.ovf    = (sSum > maxS) || (sSum < minS);
      end
      5'd3: begin
        m.result = a - b;
        m.carry  = (a >= b);
        sSum     = longint'($signed(a)) - longint'($signed(b));
        m.ovf    = (sSum > maxS) || (sSum < minS);
      end
      5'd4: m.result = a ^ b;
      5'd5: m.result = a << b[4:0];
      5'd6: m.result = a >> b[4:0];
      5'd7: m.set = (a < b);
      5'd8: m.set = ($signed(a) < $signed(b));
      5'd9: m.set = ($signed(a) >= $signed(b));
      default: m.result = 32'd0;
    endcase
    if (op == 5'd7 || op == 5'd8 || op == 5'd9) m.result = {31'd0, m.set};
    m.zero = (m.result == 32'd0);
    return m;
  endfunction

  // Drive one operation on the falling edge and push its expected outputs
  task automatic applyStimulus(input string tag, input logic rstVal,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] op);
    expect_t e;
    @(negedge clk);
    rst   = rstVal;
    opA   = a;
    opB   = b;
    opSel = op;
    if (rstVal) begin
      e.result = 32'd0;
      e.carry  = 1'b0;
      e.ovf    = 1'b0;
      e.zero   = 1'b1;
      e.set    = 1'b0;
    end else begin
      e = modelAlu(a, b, op);
    end
    e.tag = tag;
    sbQueue.push_back(e);
  endtask

  // Drive one float add; the float result only exists when the adder is built
  task automatic applyFloat(input string tag, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] expResult);
    expect_t e;
    @(negedge clk);
    rst   = 1'b0;
    opA   = a;
    opB   = b;
    opSel = 5'b01111;
`ifdef ALU_FPADD_EN
    e.result = expResult;
`else
    e.result = 32'd0;
    if (expResult == 32'd0) e.result = 32'd0;
`endif
    e.carry = 1'b0;
    e.ovf   = 1'b0;
    e.set   = 1'b0;
    e.zero  = (e.result == 32'd0);
    e.tag   = tag;
    sbQueue.push_back(e);
  endtask

  // Monitor: compare each registered result just after the rising edge
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbQueue.size() > 0) begin
        e = sbQueue.pop_front();
        checkOutput({e.tag, ".result"},   result,           e.result);
        checkOutput({e.tag, ".carry"},    {31'd0, carryOut}, {31'd0, e.carry});
        checkOutput({e.tag, ".overflow"}, {31'd0, overflow}, {31'd0, e.ovf});
        checkOutput({e.tag, ".zero"},     {31'd0, zero},     {31'd0, e.zero});
        checkOutput({e.tag, ".set"},      {31'd0, setFlag},  {31'd0, e.set});
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rop;
    logic        rrst;
    rst   = 1'b1;
    opA   = 32'd0;
    opB   = 32'd0;
    opSel = 5'd0;

    // Reset overrides a pending SUB; the first real result follows release
    applyStimulus("reset",     1'b1, 32'd5, 32'd4, 5'b00011);
    applyStimulus("postReset", 1'b0, 32'd5, 32'd4, 5'b00011);

    // Add flags
    applyStimulus("addOvf",   1'b0, 32'd100,      32'h7FFFFFFD, 5'b00010);
    applyStimulus("addWrap",  1'b0, 32'hFFFFFFFF, 32'd1,        5'b00010);
    applyStimulus("addNeg",   1'b0, -32'sd45,     -32'sd20,     5'b00010);

    // Shifts and logic
    applyStimulus("sll",      1'b0, 32'd1023, 32'd2, 5'b00101);
    applyStimulus("srl",      1'b0, 32'd1023, 32'd2, 5'b00110);
    applyStimulus("sllMax",   1'b0, 32'h8000_0001, 32'hFFFF_FFFF, 5'b00101);
    applyStimulus("and",      1'b0, 32'd7,  32'd5, 5'b00000);
    applyStimulus("or",       1'b0, 32'd1,  32'd4, 5'b00001);
    applyStimulus("xor",      1'b0, 32'd13, 32'd7, 5'b00100);

    // Compares
    applyStimulus("slt",      1'b0, -32'sd15,     -32'sd7, 5'b01000);
    applyStimulus("sltu",     1'b0, 32'd1024,     32'd2133, 5'b00111);
    applyStimulus("sgeq",     1'b0, 32'd3024,     32'd2133, 5'b01001);
    applyStimulus("sltuBig",  1'b0, 32'hFFFFFFFF, 32'd1,    5'b00111);
    applyStimulus("sgeqEq",   1'b0, 32'h8000_0000, 32'h8000_0000, 5'b01001);

    // Subtract
    applyStimulus("subNeg",   1'b0, -32'sd5,       -32'sd70, 5'b00011);
    applyStimulus("subOvf",   1'b0, 32'h80000000,  32'd1,    5'b00011);

    // Undefined opcodes
    applyStimulus("undef10",  1'b0, 32'hDEADBEEF, 32'h12345678, 5'd10);
    applyStimulus("undef31",  1'b0, 32'hDEADBEEF, 32'h12345678, 5'd31);

    // Float add, issued back to back
    applyFloat("fpAdd",      32'h41700000, 32'h43700000, 32'h437F0000);
    applyFloat("fpAddAgain", 32'h41700000, 32'h43700000, 32'h437F0000);
    applyFloat("fpInfNan",   32'h7F800000, 32'hFF800000, 32'h7FC00000);
    applyFloat("fpOnes",     32'h3F800000, 32'h3F800000, 32'h40000000);
    applyFloat("fpCancel",   32'h3F800000, 32'hBF800000, 32'h00000000);
    applyFloat("fpNanIn",    32'h7F800001, 32'h3F800000, 32'h7FC00000);
    applyFloat("fpInfPass",  32'h3F800000, 32'hFF800000, 32'hFF800000);
    applyFloat("fpSatInf",   32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    applyFloat("fpTruncAdd", 32'h3F800000, 32'h33800000, 32'h3F800000);
    applyFloat("fpTruncSub", 32'h3F800000, 32'hB3000000, 32'h3F7FFFFF);
    applyFloat("fpDenorm",   32'h00400000, 32'h3F800000, 32'h3F800000);

    // Random mix of integer ops, undefined opcodes and occasional resets
    for (int i = 0; i < 80; i++) begin
      ra   = $urandom;
      rb   = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rop  = 5'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) begin
        rop = 5'($urandom_range(10, 31));
        if (rop == 5'b01111) rop = 5'd14;
      end
      rrst = ($urandom_range(0, 15) == 0);
      applyStimulus("random", rrst, ra, rb, rop);
    end

    // Let the last result come out, then confirm nothing is left pending
    repeat (3) @(posedge clk);
    #2;
    checkOutput("drain", 32'(sbQueue.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
